// File: rtl/sdram_pkg.sv
// Shared types and defaults for the SDRAM burst-read responder.
// Defaults: 16-word bursts (64 bytes) over a 26-bit byte address space.
// Contents: burst geometry localparams, address type and FSM state type.
package sdram_pkg;

    localparam int BURST_LEN   = 16;
    localparam int ADDR_W      = 26;
    localparam int BURST_BYTES = BURST_LEN * 4;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } burst_state_t;

endpackage

// File: rtl/sdram_burst_responder.sv
// Burst-read responder: takes one client burst request at a time, issues a
// burst-aligned command to the SDRAM controller and streams the returned words
// back. Each word is tagged with its byte address, and the last word is flagged.
// Latency: client_ready is combinational; each mem_rvalid beat appears on client_rvalid one cycle later.
// Backpressure: none on data. A request is held by the client until ready, and mem_req is held until mem_ack.
// Ports: clock/reset_n; client_request/ready/address in, client_rvalid/rdata/raddress/complete out;
//        mem_req/mem_addr out, mem_ack/mem_rvalid/mem_rdata in.
module sdram_burst_responder
    import sdram_pkg::*;
#(
    parameter int BURST_LEN = sdram_pkg::BURST_LEN,
    parameter int ADDR_W    = sdram_pkg::ADDR_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              client_request,
    output logic              client_ready,
    input  logic [ADDR_W-1:0] client_address,
    output logic              client_rvalid,
    output logic [31:0]       client_rdata,
    output logic [ADDR_W-1:0] client_raddress,
    output logic              client_complete,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    localparam int BEAT_W = $clog2(BURST_LEN);
    localparam int OFF_W  = $clog2(BURST_LEN * 4);
    localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'((BURST_LEN * 4) - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    burst_state_t      state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              mem_req_q, mem_req_d;
    logic              rvalid_q, rvalid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic              complete_q, complete_d;
    // Sticky debug flag: controller returned data while no burst was outstanding.
    logic              err_stray_q, err_stray_d;
    logic              take_beat;

    // A beat that arrives together with mem_ack already belongs to this burst.
    assign take_beat = mem_rvalid && ((state_q == CMD && mem_ack) || state_q == DATA);

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        beat_d       = beat_q;
        mem_req_d    = mem_req_q;
        rvalid_d     = 1'b0;
        rdata_d      = rdata_q;
        raddr_d      = raddr_q;
        complete_d   = 1'b0;
        err_stray_d  = err_stray_q;
        client_ready = 1'b0;

        case (state_q)
            IDLE: begin
                client_ready = client_request;
                if (mem_rvalid) begin
                    err_stray_d = 1'b1;
                end
                if (client_request) begin
                    base_d    = client_address & ~OFF_MASK;
                    beat_d    = '0;
                    mem_req_d = 1'b1;
                    state_d   = CMD;
                end
            end
            CMD: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = DATA;
                end
            end
            DATA: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (take_beat) begin
            rvalid_d = 1'b1;
            rdata_d  = mem_rdata;
            // The base is burst-aligned, so OR-ing in the offset never carries
            // into the upper bits, even for the top burst of the address space.
            raddr_d  = base_q | {{(ADDR_W - OFF_W){1'b0}}, beat_q, 2'b00};
            beat_d   = beat_q + BEAT_W'(1);
            if (beat_q == LAST_BEAT) begin
                complete_d = 1'b1;
                // Returning to IDLE here lets the next request be accepted in
                // the same cycle that complete is presented.
                state_d    = IDLE;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            base_q      <= '0;
            beat_q      <= '0;
            mem_req_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            raddr_q     <= '0;
            complete_q  <= 1'b0;
            err_stray_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            beat_q      <= beat_d;
            mem_req_q   <= mem_req_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            raddr_q     <= raddr_d;
            complete_q  <= complete_d;
            err_stray_q <= err_stray_d;
        end
    end

    assign client_rvalid   = rvalid_q;
    assign client_rdata    = rdata_q;
    assign client_raddress = raddr_q;
    assign client_complete = complete_q;
    assign mem_req         = mem_req_q;
    assign mem_addr        = base_q;

endmodule

// File: tb/tb_sdram_burst_responder.sv
// Directed bench for sdram_burst_responder: reset, aligned/unaligned bursts,
// data beats with gaps, back-to-back requests, the top-of-space burst, a
// mid-burst reset and data that arrives while idle.
module tb_sdram_burst_responder;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        client_request;
    logic        client_ready;
    logic [25:0] client_address;
    logic        client_rvalid;
    logic [31:0] client_rdata;
    logic [25:0] client_raddress;
    logic        client_complete;
    logic        mem_req;
    logic        mem_ack;
    logic [25:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_chk  = 0;
    int n_pass = 0;
    int sent   = 0;
    int seen   = 0;

    always #5 clock = ~clock;

    sdram_burst_responder dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .client_request (client_request),
        .client_ready   (client_ready),
        .client_address (client_address),
        .client_rvalid  (client_rvalid),
        .client_rdata   (client_rdata),
        .client_raddress(client_raddress),
        .client_complete(client_complete),
        .mem_req        (mem_req),
        .mem_ack        (mem_ack),
        .mem_addr       (mem_addr),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata)
    );

    // Counts every word delivered to the client, sampled mid-cycle.
    always @(negedge clock) begin
        if (reset_n && client_rvalid) seen++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    // Present one controller beat (optionally with mem_ack), then idle for gap cycles.
    task automatic beat(input logic [31:0] d, input int gap, input logic [25:0] exp_addr,
                        input logic exp_cmp, input logic with_ack);
        mem_rvalid = 1'b1;
        mem_rdata  = d;
        mem_ack    = with_ack;
        @(posedge clock); #1;
        mem_rvalid = 1'b0;
        mem_ack    = 1'b0;
        sent++;
        check_eq("rvalid",   client_rvalid,   1);
        check_eq("rdata",    client_rdata,    d);
        check_eq("raddress", client_raddress, exp_addr);
        check_eq("complete", client_complete, exp_cmp);
        if (with_ack) check_eq("mem_req_drop", mem_req, 0);
        for (int g = 0; g < gap; g++) begin
            @(posedge clock); #1;
            check_eq("gap_rvalid", client_rvalid, 0);
            check_eq("gap_hold",   client_rdata,  d);
        end
    endtask

    // Request a burst, check the command, hold a pending request in CMD, then return nbeats.
    task automatic run_burst(input logic [25:0] a, input logic [25:0] base,
                             input logic [31:0] dbase, input int gapmode, input int nbeats);
        client_request = 1'b1;
        client_address = a;
        #1;
        check_eq("ready", client_ready, 1);
        @(posedge clock); #1;
        check_eq("ready_pulse", client_ready, 0);
        check_eq("mem_req",  mem_req,  1);
        check_eq("mem_addr", mem_addr, base);
        @(posedge clock); #1;
        client_request = 1'b0;
        check_eq("mem_req_hold",  mem_req,  1);
        check_eq("mem_addr_hold", mem_addr, base);
        for (int i = 0; i < nbeats; i++) begin
            beat(dbase + i, gapmode ? ((i * 7 + 3) % 6) : 0, base + 26'(4 * i),
                 (i == 15), (i == 0));
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        client_request = 1'b0;
        client_address = '0;
        mem_ack        = 1'b0;
        mem_rvalid     = 1'b0;
        mem_rdata      = '0;
        #12;
        check_eq("rst_ready",    client_ready,    0);
        check_eq("rst_rvalid",   client_rvalid,   0);
        check_eq("rst_rdata",    client_rdata,    0);
        check_eq("rst_raddress", client_raddress, 0);
        check_eq("rst_complete", client_complete, 0);
        check_eq("rst_mem_req",  mem_req,         0);
        check_eq("rst_mem_addr", mem_addr,        0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Unaligned request, back-to-back beats, first beat with ack.
        run_burst(26'h0001234, 26'h0001200, 32'hA000_0000, 0, 16);
        @(posedge clock); #1;
        check_eq("after_complete", client_complete, 0);
        check_eq("after_rvalid",   client_rvalid,   0);

        // Beats with 0-5 idle cycles between them.
        run_burst(26'h0000050, 26'h0000040, 32'hB000_0000, 1, 16);
        @(posedge clock); #1;

        // Request held high across four bursts: each complete overlaps the next ready.
        client_request = 1'b1;
        client_address = 26'h0000213;
        #1;
        check_eq("b2b_first_ready", client_ready, 1);
        for (int b = 0; b < 4; b++) begin
            @(posedge clock); #1;
            check_eq("b2b_mem_req",  mem_req,      1);
            check_eq("b2b_mem_addr", mem_addr,     26'h0000200);
            check_eq("b2b_no_ready", client_ready, 0);
            for (int i = 0; i < 16; i++) begin
                beat(32'hC000_0000 + 32'(b * 16 + i), 0, 26'h0000200 + 26'(4 * i),
                     (i == 15), (i == 0));
            end
            check_eq("b2b_ready", client_ready, 1);
            if (b == 3) client_request = 1'b0;
        end
        @(posedge clock); #1;

        // Top burst of the address space: no carry into the upper bits.
        run_burst(26'h3FFFFF8, 26'h3FFFFC0, 32'hD000_0000, 0, 16);
        check_eq("top_last_raddr", client_raddress, 26'h3FFFFFC);
        @(posedge clock); #1;

        // Reset after five beats of a burst.
        run_burst(26'h0000777, 26'h0000740, 32'hE000_0000, 0, 5);
        @(negedge clock); #1;
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_rvalid",   client_rvalid,   0);
        check_eq("mid_rst_rdata",    client_rdata,    0);
        check_eq("mid_rst_raddress", client_raddress, 0);
        check_eq("mid_rst_complete", client_complete, 0);
        check_eq("mid_rst_mem_req",  mem_req,         0);
        check_eq("mid_rst_mem_addr", mem_addr,        0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        run_burst(26'h0000ABC, 26'h0000A80, 32'hF000_0000, 0, 16);
        @(posedge clock); #1;

        // Data arriving with no burst outstanding is dropped and flagged.
        check_eq("stray_clear", dut.err_stray_q, 0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_AAAA;
        @(posedge clock); #1;
        mem_rvalid = 1'b0;
        check_eq("stray_rvalid", client_rvalid, 0);
        check_eq("stray_flag",   dut.err_stray_q, 1);
        @(posedge clock); #1;
        check_eq("stray_sticky", dut.err_stray_q, 1);
        check_eq("stray_rvalid2", client_rvalid, 0);
        check_eq("stray_rdata_hold", client_rdata, 32'hF000_000F);

        check_eq("beat_count", seen, sent);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
